// File: rtl/cdce62005_spi_responder.sv
// cdce62005_spi_responder
// SPI target that mimics the CDCE62005 register interface: LSB-first 32-bit
// frames framed by active-low spi_le, register writes to addresses 0..8,
// readback command 0xE, and the 0x1F EEPROM copy command. All SPI pins are
// oversampled in the clk domain.
// Optional feature macro: CDCE_RESP_EEPROM_EN (EEPROM shadow + EE_BUSY state).

module cdce62005_spi_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int EE_BUSY_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_le,
  output logic        spi_miso,
  output logic        wr_stb,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_err,
  output logic        eeprom_busy,
  input  logic [3:0]  reg_sel,
  output logic [31:0] reg_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_LATCH,
    S_RD_ARMED,
    S_TX
`ifdef CDCE_RESP_EEPROM_EN
    , S_EE_BUSY
`endif
  } state_t;

  state_t r_state, w_state_nxt;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_le_sync;
  logic                   r_sclk_q, r_le_q;

  // Datapath registers
  logic [31:0] r_rx_sr;
  logic [5:0]  r_bitcnt;
  logic [31:0] r_tx_sr;
  logic [31:0] r_regs [0:8];
  logic        r_miso;
  logic        r_wr_stb;
  logic [3:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_frame_err;

  // Edge detects on the synchronized pins
  logic w_sclk, w_le, w_mosi;
  logic w_rise, w_fall, w_le_rise, w_le_fall;

  // Frame decode
  logic        w_len_ok, w_is_wr, w_is_rd;
  logic [3:0]  w_rd_addr;
  logic [31:0] w_rd_word;

  // Control strobes from the FSM
  logic w_rx_clear, w_rx_shift, w_commit, w_err;
  logic w_tx_load, w_tx_shift, w_miso_nxt;

`ifdef CDCE_RESP_EEPROM_EN
  localparam int EE_CW = (EE_BUSY_CYCLES > 1) ? $clog2(EE_BUSY_CYCLES) : 1;
  logic [31:0]      r_ee_shadow [0:7];
  logic [EE_CW-1:0] r_ee_cnt;
  logic             r_eeprom_busy;
  logic             r_ee_rx;
  logic             w_ee_rx_nxt, w_ee_start, w_ee_last, w_is_ee;

  assign w_is_ee   = (r_rx_sr[4:0] == 5'h1F);
  assign w_ee_last = r_eeprom_busy && (r_ee_cnt == EE_CW'(EE_BUSY_CYCLES - 1));
  assign eeprom_busy = r_eeprom_busy;
`else
  assign eeprom_busy = 1'b0;
`endif

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_le      = r_le_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_q;
  assign w_fall    = ~w_sclk & r_sclk_q;
  assign w_le_rise = w_le & ~r_le_q;
  assign w_le_fall = ~w_le & r_le_q;

  assign w_len_ok  = (r_bitcnt == 6'd32);
  assign w_is_wr   = (r_rx_sr[3:0] <= 4'd8);
  assign w_is_rd   = (r_rx_sr[3:0] == 4'hE);
  assign w_rd_addr = r_rx_sr[7:4];
  assign w_rd_word = (w_rd_addr <= 4'd8) ? r_regs[w_rd_addr] : 32'h0;

  assign spi_miso  = r_miso;
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign reg_dout  = (reg_sel <= 4'd8) ? r_regs[reg_sel] : 32'h0;

  // Synchronize the SPI pins into clk and keep one cycle of history for edges
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_le_sync   <= '1;
      r_sclk_q    <= 1'b0;
      r_le_q      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_le_sync   <= {r_le_sync[SYNC_STAGES-2:0], spi_le};
      r_sclk_q    <= w_sclk;
      r_le_q      <= w_le;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_rx_clear  = 1'b0;
    w_rx_shift  = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_miso_nxt  = 1'b0;
`ifdef CDCE_RESP_EEPROM_EN
    w_ee_start  = 1'b0;
    w_ee_rx_nxt = r_ee_rx;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_le_fall) begin
          w_rx_clear  = 1'b1;
          w_state_nxt = S_RX;
        end
      end
      S_RX: begin
        // A rise coincident with le_rise is dropped.
        if (w_le_rise)   w_state_nxt = S_LATCH;
        else if (w_rise) w_rx_shift  = 1'b1;
      end
      S_LATCH: begin
        if (!w_len_ok)    w_err     = 1'b1;
        else if (w_is_wr) w_commit  = 1'b1;
        else if (w_is_rd) w_tx_load = 1'b1;
`ifdef CDCE_RESP_EEPROM_EN
        else if (w_is_ee) w_ee_start = 1'b1;
`endif
        else              w_err     = 1'b1;

        // A new frame may already be starting in this cycle.
        if (w_tx_load) begin
          if (w_le_fall) begin
            w_state_nxt = S_TX;
            w_miso_nxt  = w_rd_word[0];
          end else begin
            w_state_nxt = S_RD_ARMED;
          end
        end
`ifdef CDCE_RESP_EEPROM_EN
        else if (w_ee_start) begin
          w_state_nxt = S_EE_BUSY;
          if (w_le_fall) begin
            w_rx_clear  = 1'b1;
            w_ee_rx_nxt = 1'b1;
          end
        end
`endif
        else if (w_le_fall) begin
          w_rx_clear  = 1'b1;
          w_state_nxt = S_RX;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_ARMED: begin
        if (w_le_fall) begin
          w_state_nxt = S_TX;
          w_miso_nxt  = r_tx_sr[0];
        end
      end
      S_TX: begin
        if (w_le_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_tx_shift = 1'b1;
          w_miso_nxt = r_tx_sr[1];
        end else begin
          w_miso_nxt = r_miso;
        end
      end
`ifdef CDCE_RESP_EEPROM_EN
      S_EE_BUSY: begin
        // Frames are received while busy but always rejected at their le_rise.
        if (r_ee_rx) begin
          if (w_le_rise) begin
            w_err       = 1'b1;
            w_ee_rx_nxt = 1'b0;
          end else if (w_rise) begin
            w_rx_shift = 1'b1;
          end
        end else if (w_le_fall) begin
          w_rx_clear  = 1'b1;
          w_ee_rx_nxt = 1'b1;
        end
        // Leave only once the copy is done and no rejected frame is in flight.
        if ((!r_eeprom_busy || w_ee_last) && !w_ee_rx_nxt) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive/transmit shifters, register file and output strobes
  // NOTE: the register file is reset because its per-address reset value is visible behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sr     <= '0;
      r_bitcnt    <= '0;
      r_tx_sr     <= '0;
      r_miso      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < 9; i++) r_regs[i] <= 32'(i);
    end else begin
      if (w_rx_clear) begin
        r_rx_sr  <= '0;
        r_bitcnt <= '0;
      end else if (w_rx_shift) begin
        r_rx_sr <= {w_mosi, r_rx_sr[31:1]};
        if (r_bitcnt != 6'd33) r_bitcnt <= r_bitcnt + 6'd1;
      end

      if (w_tx_load)       r_tx_sr <= w_rd_word;
      else if (w_tx_shift) r_tx_sr <= {1'b0, r_tx_sr[31:1]};

      r_miso      <= w_miso_nxt;
      r_wr_stb    <= w_commit;
      r_frame_err <= w_err;

      if (w_commit) begin
        r_regs[r_rx_sr[3:0]] <= r_rx_sr;
        r_wr_addr            <= r_rx_sr[3:0];
        r_wr_data            <= r_rx_sr;
      end
    end
  end

`ifdef CDCE_RESP_EEPROM_EN
  // EEPROM shadow copy and busy timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eeprom_busy <= 1'b0;
      r_ee_cnt      <= '0;
      r_ee_rx       <= 1'b0;
      for (int i = 0; i < 8; i++) r_ee_shadow[i] <= '0;
    end else begin
      r_ee_rx <= w_ee_rx_nxt;
      if (w_ee_start) begin
        for (int i = 0; i < 8; i++) r_ee_shadow[i] <= r_regs[i];
        r_eeprom_busy <= 1'b1;
        r_ee_cnt      <= '0;
      end else if (r_eeprom_busy) begin
        if (w_ee_last) r_eeprom_busy <= 1'b0;
        else           r_ee_cnt      <= r_ee_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// Directed testbench for cdce62005_spi_responder. A second instance with
// SYNC_STAGES=3 listens to the same SPI pins, driven at clk/8.

module tb_cdce62005_spi_responder;

  localparam int HP = 4;  // clk cycles per spi_clk half period (spi_clk = clk/8)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_le = 1'b1;
  logic [3:0]  reg_sel = 4'd0;

  logic        spi_miso, wr_stb, frame_err, eeprom_busy;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data, reg_dout;

  logic        spi_miso3, wr_stb3, frame_err3, eeprom_busy3;
  logic [3:0]  wr_addr3;
  logic [31:0] wr_data3, reg_dout3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stb_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int stb3_cnt = 0, err3_cnt = 0;
  int last_stb_cyc = 0, last_err_cyc = 0, last_stb3_cyc = 0;
  int le_up_cyc = 0;

  logic [31:0] wvec [0:8] = '{32'h81400320, 32'h81400321, 32'hEB060302,
                              32'h68860303, 32'hEB060314, 32'h68860315,
                              32'hEB840316, 32'h000009F7, 32'h80001808};

  cdce62005_spi_responder #(.SYNC_STAGES(2), .EE_BUSY_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_le(spi_le),
    .spi_miso(spi_miso), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .eeprom_busy(eeprom_busy), .reg_sel(reg_sel), .reg_dout(reg_dout)
  );

  cdce62005_spi_responder #(.SYNC_STAGES(3), .EE_BUSY_CYCLES(1000)) dut3 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_le(spi_le),
    .spi_miso(spi_miso3), .wr_stb(wr_stb3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .frame_err(frame_err3), .eeprom_busy(eeprom_busy3), .reg_sel(reg_sel), .reg_dout(reg_dout3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and timestamps, sampled on the inactive edge
  always @(negedge clk) begin
    if (wr_stb)      begin stb_cnt  <= stb_cnt + 1;  last_stb_cyc  <= cyc; end
    if (frame_err)   begin err_cnt  <= err_cnt + 1;  last_err_cyc  <= cyc; end
    if (eeprom_busy) busy_cnt <= busy_cnt + 1;
    if (wr_stb3)     begin stb3_cnt <= stb3_cnt + 1; last_stb3_cyc <= cyc; end
    if (frame_err3)  err3_cnt <= err3_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic spi_begin();
    spi_clk = 1'b0;
    spi_le  = 1'b0;
    tick(HP);
  endtask

  task automatic spi_bits(input logic [63:0] d, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[i];
      tick(HP);
      if (i < 32) cap[i] = spi_miso;
      spi_clk = 1'b1;
      tick(HP);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_end();
    tick(HP);
    spi_le    = 1'b1;
    le_up_cyc = cyc;
    spi_mosi  = 1'b0;
    tick(4 * HP);
  endtask

  task automatic send(input logic [31:0] d);
    logic [31:0] c;
    spi_begin();
    spi_bits({32'h0, d}, 32, c);
    spi_end();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    checks++; if (spi_miso !== 1'b0)    begin failures++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++; if (wr_stb !== 1'b0)      begin failures++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
    checks++; if (frame_err !== 1'b0)   begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (eeprom_busy !== 1'b0) begin failures++; $display("FAIL reset_eeprom_busy: got %b expected 0", eeprom_busy); end
    checks++; if (wr_addr !== 4'h0)     begin failures++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 32'h0)    begin failures++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    for (int n = 0; n < 10; n++) begin
      reg_sel = 4'(n);
      #1;
      checks++;
      if (reg_dout !== ((n <= 8) ? 32'(n) : 32'h0)) begin
        failures++; $display("FAIL reset_reg_dout[%0d]: got %h expected %h", n, reg_dout, (n <= 8) ? 32'(n) : 32'h0);
      end
    end
  endtask

  task automatic test_write();
    int s0, e0, s30, e30;
    s0 = stb_cnt; e0 = err_cnt; s30 = stb3_cnt; e30 = err3_cnt;
    for (int n = 0; n < 9; n++) send(wvec[n]);
    checks++; if (stb_cnt - s0 !== 9)  begin failures++; $display("FAIL write_stb_count: got %0d expected 9", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0)  begin failures++; $display("FAIL write_err_count: got %0d expected 0", err_cnt - e0); end
    checks++; if (wr_addr !== 4'd8)    begin failures++; $display("FAIL write_last_addr: got %h expected 8", wr_addr); end
    checks++; if (wr_data !== 32'h80001808) begin failures++; $display("FAIL write_last_data: got %h expected 80001808", wr_data); end
    checks++; if (last_stb_cyc - le_up_cyc !== 4) begin failures++; $display("FAIL write_stb_latency: got %0d expected 4", last_stb_cyc - le_up_cyc); end
    for (int n = 0; n < 9; n++) begin
      reg_sel = 4'(n);
      #1;
      checks++; if (reg_dout !== wvec[n])  begin failures++; $display("FAIL write_reg_dout[%0d]: got %h expected %h", n, reg_dout, wvec[n]); end
      checks++; if (reg_dout3 !== wvec[n]) begin failures++; $display("FAIL write_sync3_reg_dout[%0d]: got %h expected %h", n, reg_dout3, wvec[n]); end
    end
    reg_sel = 4'd15;
    #1;
    checks++; if (reg_dout !== 32'h0) begin failures++; $display("FAIL write_reg_dout_sel15: got %h expected 0", reg_dout); end
    checks++; if (stb3_cnt - s30 !== 9) begin failures++; $display("FAIL write_sync3_stb_count: got %0d expected 9", stb3_cnt - s30); end
    checks++; if (err3_cnt - e30 !== 0) begin failures++; $display("FAIL write_sync3_err_count: got %0d expected 0", err3_cnt - e30); end
    checks++; if (last_stb3_cyc - le_up_cyc !== 5) begin failures++; $display("FAIL write_sync3_stb_latency: got %0d expected 5", last_stb3_cyc - le_up_cyc); end
  endtask

  task automatic test_readback();
    int s0, e0;
    logic [31:0] cap;
    s0 = stb_cnt; e0 = err_cnt;
    send(32'hEB060314);
    send(32'h0000004E);
    spi_begin();
    spi_bits(64'h0, 32, cap);
    spi_end();
    checks++; if (cap !== 32'hEB060314) begin failures++; $display("FAIL readback_reg4: got %h expected EB060314", cap); end
    checks++; if (spi_miso !== 1'b0)    begin failures++; $display("FAIL readback_idle_miso: got %b expected 0", spi_miso); end
    send(32'h000000AE);
    spi_begin();
    spi_bits(64'h0, 32, cap);
    spi_end();
    checks++; if (cap !== 32'h0)       begin failures++; $display("FAIL readback_addr_a: got %h expected 0", cap); end
    checks++; if (stb_cnt - s0 !== 1)  begin failures++; $display("FAIL readback_stb_count: got %0d expected 1", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0)  begin failures++; $display("FAIL readback_err_count: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_bad_frames();
    int s0, e0;
    logic [31:0] cap;
    s0 = stb_cnt; e0 = err_cnt;
    spi_begin();
    spi_bits(64'h5, 31, cap);
    spi_end();
    checks++; if (last_err_cyc - le_up_cyc !== 4) begin failures++; $display("FAIL bad_err_latency: got %0d expected 4", last_err_cyc - le_up_cyc); end
    spi_begin();
    spi_bits(64'h5, 34, cap);
    spi_end();
    checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL bad_length_err_count: got %0d expected 2", err_cnt - e0); end
    send(32'h0000000B);
    send(32'h0000000F);
    checks++; if (err_cnt - e0 !== 4) begin failures++; $display("FAIL bad_addr_err_count: got %0d expected 4", err_cnt - e0); end
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL bad_stb_count: got %0d expected 0", stb_cnt - s0); end
    reg_sel = 4'd5;
    #1;
    checks++; if (reg_dout !== 32'h68860315) begin failures++; $display("FAIL bad_reg5_kept: got %h expected 68860315", reg_dout); end
  endtask

  task automatic test_eeprom();
    int s0, e0, b0, n;
    s0 = stb_cnt; e0 = err_cnt; b0 = busy_cnt;
    send(32'h0000001F);
`ifdef CDCE_RESP_EEPROM_EN
    checks++; if (eeprom_busy !== 1'b1) begin failures++; $display("FAIL ee_busy_high: got %b expected 1", eeprom_busy); end
    send(32'h00000005);
    n = 0;
    while (eeprom_busy === 1'b1 && n < 3000) begin tick(1); n++; end
    checks++; if (eeprom_busy !== 1'b0) begin failures++; $display("FAIL ee_busy_timeout: got %b expected 0", eeprom_busy); end
    tick(4);
    checks++; if (busy_cnt - b0 !== 1000) begin failures++; $display("FAIL ee_busy_cycles: got %0d expected 1000", busy_cnt - b0); end
    checks++; if (err_cnt - e0 !== 1)     begin failures++; $display("FAIL ee_err_count: got %0d expected 1", err_cnt - e0); end
`else
    n = 0;
    tick(20);
    checks++; if (busy_cnt - b0 !== 0) begin failures++; $display("FAIL ee_busy_cycles: got %0d expected 0", busy_cnt - b0); end
    checks++; if (err_cnt - e0 !== 1)  begin failures++; $display("FAIL ee_err_count: got %0d expected 1", err_cnt - e0); end
`endif
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL ee_stb_count: got %0d expected 0", stb_cnt - s0); end
    reg_sel = 4'd5;
    #1;
    checks++; if (reg_dout !== 32'h68860315) begin failures++; $display("FAIL ee_reg5_kept: got %h expected 68860315", reg_dout); end
  endtask

  task automatic test_reset_midframe();
    int s0;
    logic [31:0] cap;
    spi_begin();
    spi_bits({32'h0, 32'h90000FF5}, 16, cap);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    spi_end();
    reg_sel = 4'd5;
    #1;
    checks++; if (reg_dout !== 32'h00000005) begin failures++; $display("FAIL midrst_reg5: got %h expected 00000005", reg_dout); end
    reg_sel = 4'd0;
    #1;
    checks++; if (reg_dout !== 32'h0) begin failures++; $display("FAIL midrst_reg0: got %h expected 0", reg_dout); end
    s0 = stb_cnt;
    send(32'h90000FF5);
    reg_sel = 4'd5;
    #1;
    checks++; if (stb_cnt - s0 !== 1)        begin failures++; $display("FAIL midrst_stb_count: got %0d expected 1", stb_cnt - s0); end
    checks++; if (reg_dout !== 32'h90000FF5) begin failures++; $display("FAIL midrst_reg5_written: got %h expected 90000FF5", reg_dout); end
    checks++; if (wr_addr !== 4'd5)          begin failures++; $display("FAIL midrst_wr_addr: got %h expected 5", wr_addr); end
    checks++; if (wr_data !== 32'h90000FF5)  begin failures++; $display("FAIL midrst_wr_data: got %h expected 90000FF5", wr_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_bad_frames();
    test_eeprom();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdce62005_spi_responder.md
# cdce62005_spi_responder

Synthesizable SPI target that models the CDCE62005 clock synthesizer's register interface, so the on-board clock configuration master can be exercised in simulation and in FPGA loopback without the real chip. It accepts 32-bit LSB-first frames delimited by active-low `spi_le` and decodes register writes (addresses 0–8), register readback commands (`0xE`) and the EEPROM copy command (`0x1F`). Readback data is returned on `spi_miso`. All SPI pins are oversampled in the single `clk` domain.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk`, `spi_mosi` and `spi_le`; minimum 2.
- `EE_BUSY_CYCLES`, 1000: `clk` cycles `eeprom_busy` stays high after `0x1F`; minimum 1.
- `clk  in  1`: system clock; the only clock.
- `rst  in  1`: asynchronous, active-high reset.
- `spi_clk  in  1`: SPI clock from the master; idles low; data is sampled on its rising edge.
- `spi_mosi  in  1`: serial data, LSB first.
- `spi_le  in  1`: frame enable; low during a frame; the rising edge latches the frame.
- `spi_miso  out  1`: readback data, LSB first, changes after `spi_clk` falling edges.
- `wr_stb  out  1`: one-cycle pulse when a register write commits.
- `wr_addr  out  4`: address of the committed write.
- `wr_data  out  32`: full 32-bit frame that was committed, including the address nibble.
- `frame_err  out  1`: one-cycle pulse when a frame is rejected.
- `eeprom_busy  out  1`: high while the EEPROM copy runs.
- `reg_sel  in  4`: debug read select.
- `reg_dout  out  32`: combinational contents of `reg[reg_sel]`; reads 0 when `reg_sel` > 8.

## Operation
- Register file: `reg[0..8]`, each 32 bits. Reset value of `reg[n]` is `{28'h0, n}`.
- Synchronized `spi_clk` is edge-detected: `rise` = sync 0→1, `fall` = sync 1→0. `le_fall` and `le_rise` are detected the same way on `spi_le`.
- Each `rise` while `spi_le` is low does two things:
  - shift `rx_sr` right, inserting `mosi` at bit 31;
  - increment `bitcnt`, saturating at 33.
- Decode at `le_rise`, in the LATCH state:
  - `bitcnt` != 32 → `frame_err`, frame discarded.
  - `rx_sr[3:0]` ≤ 8 → `reg[rx_sr[3:0]] <= rx_sr`, and `wr_stb` pulses with the address and data.
  - `rx_sr[3:0]` == `4'hE` → `tx_sr <= reg[rx_sr[7:4]]`, or 0 if that address is > 8; go to RD_ARMED.
  - `rx_sr[4:0]` == `5'h1F` → EEPROM copy (see Configuration).
  - `rx_sr[3:0]` in `9..D`, or `F` with bit 4 = 0 → `frame_err`.
- States:
  - IDLE: `le_fall` → RX; clear `bitcnt` and `rx_sr`.
  - RX: `le_rise` → LATCH.
  - LATCH: decode, then go to IDLE, RD_ARMED or EE_BUSY.
  - RD_ARMED: `le_fall` → TX; `spi_miso <= tx_sr[0]`.
  - TX: on each `fall`, shift `tx_sr` right and drive `spi_miso <= tx_sr[1]` (the bit that becomes bit 0). MOSI is ignored in TX. `le_rise` → IDLE.
  - EE_BUSY: count `EE_BUSY_CYCLES`, then go to IDLE.
- In IDLE and RD_ARMED, `spi_miso` = 0.
- A frame that starts during EE_BUSY is received. At its `le_rise` it is discarded with `frame_err`. `eeprom_busy` is not extended.
- Simultaneous events:
  - `rise` and `le_rise` in the same cycle: the rise is ignored.
  - `le_fall` in the cycle LATCH completes: the new frame starts normally.
- `rst` mid-frame: everything returns to reset values immediately, and the next frame starts from IDLE.

## Timing
- Reset values:
  - `spi_miso` = 0, `wr_stb` = 0, `frame_err` = 0, `eeprom_busy` = 0;
  - `wr_addr` = 0, `wr_data` = 0;
  - state = IDLE, `bitcnt` = 0.
- `spi_clk` high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` cycles. `spi_mosi` must be stable `SYNC_STAGES` cycles around `rise`.
- `wr_stb` and `frame_err` assert exactly `SYNC_STAGES`+2 `clk` cycles after the `spi_le` pin rises.
- `reg` updates in the same cycle as `wr_stb`.
- `spi_miso` is valid `SYNC_STAGES`+2 cycles after the `spi_le` or `spi_clk` pin falls, well before the next rising edge.
- `eeprom_busy` rises in the LATCH cycle. It stays high for exactly `EE_BUSY_CYCLES` cycles.

## Configuration
- `CDCE_RESP_EEPROM_EN` defined:
  - adds `ee_shadow[0..7]`;
  - a `0x1F` frame copies `reg[0..7]` to `ee_shadow` in the LATCH cycle, asserts `eeprom_busy` and enters EE_BUSY;
  - `reg_sel` = `4'hF` with `reg_sel`… no extra port is added: `reg_sel` 9..15 return 0 as before.
- `CDCE_RESP_EEPROM_EN` undefined:
  - no shadow and no EE_BUSY state;
  - `eeprom_busy` is tied to 0;
  - a `0x1F` frame produces `frame_err` and no other effect.

## Test plan
- Write `0x81400320`, `0x81400321`, `0xEB060302` … `0x80001808` (reg 0–8) → nine `wr_stb` pulses; `reg_dout` for `reg_sel`=3 reads `0x68860303`; `reg_sel`=8 reads `0x80001808`.
- Write `0xEB060314`, then read command `0x0000004E`, then a 32-clock LE-low frame → 32 MISO bits captured LSB first equal `0xEB060314`; read command `0x000000AE` → readback 0.
- Frame with 31 clocks, then frame with 34 clocks → two `frame_err` pulses, no `wr_stb`, registers unchanged.
- Write `0x0000001F` with `EE_BUSY_CYCLES`=1000, macro defined → `eeprom_busy` high for exactly 1000 cycles. A write of `0x00000005` sent during busy gives `frame_err` and `reg[5]` unchanged. Without the macro → a single `frame_err` and `eeprom_busy` stays 0.
- Assert `rst` after 16 bits of a write of `0x90000FF5` → `reg[5]` = `0x00000005`; the next full frame `0x90000FF5` commits normally.
- Master at `spi_clk` = `clk`/8 with `SYNC_STAGES`=3 → all frames from the first scenario are received without error.
